// File: rtl/ram_rx_chk.sv
// Read-back checker for the 4 KB test-pattern RAM: reads NUM bytes from address 0,
// compares each against {addr[11:8]} + addr[7:0] + bias and reports mismatches.
module ram_rx_chk #(
    parameter int NUM    = 12'hF00,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs,
    output logic        fd,
    input  logic [7:0]  bias,
    output logic [11:0] ram_rxa,
    output logic        ram_rxen,
    input  logic [7:0]  ram_rxd,
    output logic [11:0] err_cnt,
    output logic        err,
    output logic [11:0] first_err_addr
);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        WAIT  = 5'b00010,
        WORK  = 5'b00100,
        DRAIN = 5'b01000,
        DONE  = 5'b10000
    } state_t;

    state_t      state;
    logic [12:0] addr_cnt;
    logic [2:0]  drain_cnt;
    logic [7:0]  bias_p0;
    logic        vld_p  [RD_LAT];
    logic [11:0] addr_p [RD_LAT];
    logic        start;
    logic        miss;

    function automatic logic [7:0] exp_byte(input logic [11:0] a, input logic [7:0] b);
        logic [7:0] s;
        s = {4'h0, a[11:8]} + a[7:0] + b;
        return s;
    endfunction

    function automatic logic [11:0] sat_inc(input logic [11:0] c);
        return (c == 12'hFFF) ? c : c + 12'd1;
    endfunction

    assign start = (state == WAIT) && fs;
    assign fd    = (state == DONE);
    assign miss  = vld_p[RD_LAT-1] && (ram_rxd != exp_byte(addr_p[RD_LAT-1], bias_p0));

    // Control: sequencing and read issue (address/enable are registered outputs)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            drain_cnt <= '0;
            bias_p0   <= '0;
            ram_rxa   <= '0;
            ram_rxen  <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= WAIT;
                WAIT: begin
                    if (fs) begin
                        state    <= WORK;
                        bias_p0  <= bias;
                        addr_cnt <= '0;
                    end
                end
                WORK: begin
                    // The counter runs one past the last address so the final read
                    // cycle is completed before leaving WORK.
                    if (addr_cnt == 13'(NUM)) begin
                        state     <= DRAIN;
                        ram_rxen  <= 1'b0;
                        ram_rxa   <= '0;
                        drain_cnt <= '0;
                    end else begin
                        ram_rxen <= 1'b1;
                        ram_rxa  <= addr_cnt[11:0];
                        addr_cnt <= addr_cnt + 13'd1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 3'(RD_LAT))
                        state <= DONE;
                    else
                        drain_cnt <= drain_cnt + 3'd1;
                end
                DONE: begin
                    if (!fs)
                        state <= WAIT;
                end
                default: begin
                    state    <= IDLE;
                    ram_rxen <= 1'b0;
                    ram_rxa  <= '0;
                end
            endcase
        end
    end

    // Stage p0..p(RD_LAT-1): valid and address travel with the outstanding read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_p[i]  <= 1'b0;
                addr_p[i] <= '0;
            end
        end else begin
            vld_p[0]  <= ram_rxen;
            addr_p[0] <= ram_rxa;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                addr_p[i] <= addr_p[i-1];
            end
        end
    end

    // Compare result stage: counters are the registered outcome of each compare
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt        <= '0;
            err            <= 1'b0;
            first_err_addr <= '0;
        end else if (start) begin
            err_cnt        <= '0;
            err            <= 1'b0;
            first_err_addr <= '0;
        end else if (miss) begin
            err_cnt <= sat_inc(err_cnt);
            err     <= 1'b1;
            if (err_cnt == 12'd0)
                first_err_addr <= addr_p[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_ram_rx_chk.sv
// Directed bench for ram_rx_chk: one RD_LAT=1 instance and one RD_LAT=3 instance,
// each with its own pattern RAM model.
module tb_ram_rx_chk;

    localparam int NUM = 12'hF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fs1, fs3;
    logic        fd1, fd3;
    logic [7:0]  bias1, bias3;
    logic [11:0] ram_rxa1, ram_rxa3;
    logic        ram_rxen1, ram_rxen3;
    logic [7:0]  ram_rxd1, ram_rxd3;
    logic [11:0] err_cnt1, err_cnt3;
    logic        err1, err3;
    logic [11:0] first1, first3;

    logic [7:0]  mem1 [4096];
    logic [7:0]  mem3 [4096];
    logic [7:0]  rd1;
    logic [7:0]  r3 [3];

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    ram_rx_chk #(.NUM(NUM), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .fs(fs1), .fd(fd1), .bias(bias1),
        .ram_rxa(ram_rxa1), .ram_rxen(ram_rxen1), .ram_rxd(ram_rxd1),
        .err_cnt(err_cnt1), .err(err1), .first_err_addr(first1)
    );

    ram_rx_chk #(.NUM(NUM), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .fs(fs3), .fd(fd3), .bias(bias3),
        .ram_rxa(ram_rxa3), .ram_rxen(ram_rxen3), .ram_rxd(ram_rxd3),
        .err_cnt(err_cnt3), .err(err3), .first_err_addr(first3)
    );

    always @(posedge clk) rd1 <= mem1[ram_rxa1];
    assign ram_rxd1 = rd1;

    always @(posedge clk) begin
        r3[0] <= mem3[ram_rxa3];
        r3[1] <= r3[0];
        r3[2] <= r3[1];
    end
    assign ram_rxd3 = r3[2];

    function automatic logic [7:0] pat(input logic [11:0] a, input logic [7:0] b);
        logic [7:0] s;
        s = {4'h0, a[11:8]} + a[7:0] + b;
        return s;
    endfunction

    task automatic fill(input bit sel, input logic [7:0] b);
        for (int i = 0; i < 4096; i++) begin
            if (sel) mem3[i] = pat(12'(i), b);
            else     mem1[i] = pat(12'(i), b);
        end
    endtask

    // Caller sits #1 after a rising edge. lat = edges after the first one until fd.
    task automatic do_run(input bit sel, input logic [7:0] b, input int lead,
                          output int lat, output int en_cnt, output int addr_bad,
                          output logic [11:0] prev_cnt);
        logic [11:0] ea;
        logic        en;
        logic        f;
        logic [11:0] a;
        ea = '0; en_cnt = 0; addr_bad = 0; lat = -1; prev_cnt = '0;
        if (sel) begin bias3 = b; fs3 = 1'b1; end
        else     begin bias1 = b; fs1 = 1'b1; end
        for (int cyc = 0; cyc < 8000; cyc++) begin
            @(posedge clk); #1;
            if (cyc == lead) begin
                if (sel) bias3 = ~b; else bias1 = ~b;
            end
            en = sel ? ram_rxen3 : ram_rxen1;
            a  = sel ? ram_rxa3  : ram_rxa1;
            f  = sel ? fd3       : fd1;
            if (en) begin
                if (a !== ea) addr_bad++;
                ea = ea + 12'd1;
                en_cnt++;
            end
            if (f) begin
                lat = cyc;
                break;
            end
            prev_cnt = sel ? err_cnt3 : err_cnt1;
        end
    endtask

    task automatic test_reset;
        n_vec++; if (fd1 !== 1'b0) begin n_miss++; $display("FAIL reset_fd got %b exp 0", fd1); end
        n_vec++; if (ram_rxen1 !== 1'b0) begin n_miss++; $display("FAIL reset_rxen got %b exp 0", ram_rxen1); end
        n_vec++; if (ram_rxa1 !== 12'h000) begin n_miss++; $display("FAIL reset_rxa got %h exp 000", ram_rxa1); end
        n_vec++; if (err_cnt1 !== 12'h000) begin n_miss++; $display("FAIL reset_err_cnt got %h exp 000", err_cnt1); end
        n_vec++; if (err1 !== 1'b0) begin n_miss++; $display("FAIL reset_err got %b exp 0", err1); end
        n_vec++; if (first1 !== 12'h000) begin n_miss++; $display("FAIL reset_first got %h exp 000", first1); end
        n_vec++; if (fd3 !== 1'b0) begin n_miss++; $display("FAIL reset_fd3 got %b exp 0", fd3); end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (fd1 !== 1'b0 || ram_rxen1 !== 1'b0) begin n_miss++; $display("FAIL idle_outputs fd=%b rxen=%b exp 0/0", fd1, ram_rxen1); end
    endtask

    task automatic test_clean;
        int lat, en_cnt, bad;
        logic [11:0] pc;
        fill(1'b0, 8'h05);
        do_run(1'b0, 8'h05, 0, lat, en_cnt, bad, pc);
        n_vec++; if (lat !== NUM + 3) begin n_miss++; $display("FAIL clean_latency got %0d exp %0d", lat, NUM + 3); end
        n_vec++; if (en_cnt !== 3840) begin n_miss++; $display("FAIL clean_rxen_cycles got %0d exp 3840", en_cnt); end
        n_vec++; if (bad !== 0) begin n_miss++; $display("FAIL clean_addr_seq got %0d bad exp 0", bad); end
        n_vec++; if (err_cnt1 !== 12'h000) begin n_miss++; $display("FAIL clean_err_cnt got %h exp 000", err_cnt1); end
        n_vec++; if (err1 !== 1'b0) begin n_miss++; $display("FAIL clean_err got %b exp 0", err1); end
        n_vec++; if (first1 !== 12'h000) begin n_miss++; $display("FAIL clean_first got %h exp 000", first1); end
        fs1 = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (fd1 !== 1'b0) begin n_miss++; $display("FAIL clean_fd_drop got %b exp 0", fd1); end
    endtask

    task automatic test_corrupt;
        int lat, en_cnt, bad;
        logic [11:0] pc;
        mem1[12'h123] = mem1[12'h123] ^ 8'h01;
        mem1[12'h800] = mem1[12'h800] ^ 8'h01;
        do_run(1'b0, 8'h05, 0, lat, en_cnt, bad, pc);
        n_vec++; if (err_cnt1 !== 12'h002) begin n_miss++; $display("FAIL corrupt_err_cnt got %h exp 002", err_cnt1); end
        n_vec++; if (err1 !== 1'b1) begin n_miss++; $display("FAIL corrupt_err got %b exp 1", err1); end
        n_vec++; if (first1 !== 12'h123) begin n_miss++; $display("FAIL corrupt_first got %h exp 123", first1); end
        fs1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (err_cnt1 !== 12'h002 || first1 !== 12'h123) begin n_miss++; $display("FAIL corrupt_hold_wait got %h/%h exp 002/123", err_cnt1, first1); end
        mem1[12'h123] = pat(12'h123, 8'h05);
        mem1[12'h800] = pat(12'h800, 8'h05);
    endtask

    task automatic test_bias_mismatch;
        int lat, en_cnt, bad;
        logic [11:0] pc;
        do_run(1'b0, 8'h06, 0, lat, en_cnt, bad, pc);
        n_vec++; if (err_cnt1 !== 12'hF00) begin n_miss++; $display("FAIL bias_err_cnt got %h exp F00", err_cnt1); end
        n_vec++; if (first1 !== 12'h000) begin n_miss++; $display("FAIL bias_first got %h exp 000", first1); end
        n_vec++; if (err1 !== 1'b1) begin n_miss++; $display("FAIL bias_err got %b exp 1", err1); end
        fs1 = 1'b0;
        @(posedge clk); #1;
        // 0x0E + 0xFF + 0x06 wraps to 0x13: that byte alone must match
        mem1[12'hEFF] = 8'h13;
        do_run(1'b0, 8'h06, 0, lat, en_cnt, bad, pc);
        n_vec++; if (err_cnt1 !== 12'hEFF) begin n_miss++; $display("FAIL bias_wrap_err_cnt got %h exp EFF", err_cnt1); end
        fs1 = 1'b0;
        @(posedge clk); #1;
        mem1[12'hEFF] = pat(12'hEFF, 8'h05);
    endtask

    task automatic test_hold_restart;
        int lat, en_cnt, bad, hold_bad;
        logic [11:0] pc;
        mem1[12'h123] = mem1[12'h123] ^ 8'h01;
        do_run(1'b0, 8'h05, 0, lat, en_cnt, bad, pc);
        n_vec++; if (err_cnt1 !== 12'h001 || first1 !== 12'h123) begin n_miss++; $display("FAIL hold_run1 got %h/%h exp 001/123", err_cnt1, first1); end
        hold_bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (fd1 !== 1'b1 || ram_rxen1 !== 1'b0) hold_bad++;
        end
        n_vec++; if (hold_bad !== 0) begin n_miss++; $display("FAIL hold_done got %0d bad cycles exp 0", hold_bad); end
        fs1 = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (fd1 !== 1'b0) begin n_miss++; $display("FAIL hold_fd_drop got %b exp 0", fd1); end
        do_run(1'b0, 8'h05, 0, lat, en_cnt, bad, pc);
        n_vec++; if (lat !== NUM + 3) begin n_miss++; $display("FAIL restart_latency got %0d exp %0d", lat, NUM + 3); end
        n_vec++; if (err_cnt1 !== 12'h001 || first1 !== 12'h123) begin n_miss++; $display("FAIL restart_results got %h/%h exp 001/123", err_cnt1, first1); end
        n_vec++; if (en_cnt !== 3840) begin n_miss++; $display("FAIL restart_rxen_cycles got %0d exp 3840", en_cnt); end
        fs1 = 1'b0;
        @(posedge clk); #1;
        mem1[12'h123] = pat(12'h123, 8'h05);
    endtask

    task automatic test_reset_midrun;
        int lat, en_cnt, bad;
        logic [11:0] pc;
        bit found;
        found = 1'b0;
        bias1 = 8'h06;
        fs1 = 1'b1;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk); #1;
            if (ram_rxa1 === 12'h400) found = 1'b1;
        end
        n_vec++; if (found !== 1'b1) begin n_miss++; $display("FAIL midrun_reach_400 got %b exp 1", found); end
        n_vec++; if (err1 !== 1'b1) begin n_miss++; $display("FAIL midrun_err_before got %b exp 1", err1); end
        rst = 1'b0;
        #1;
        n_vec++; if (ram_rxen1 !== 1'b0 || fd1 !== 1'b0) begin n_miss++; $display("FAIL midrun_async_ctl rxen=%b fd=%b exp 0/0", ram_rxen1, fd1); end
        n_vec++; if (err_cnt1 !== 12'h000 || err1 !== 1'b0 || first1 !== 12'h000) begin n_miss++; $display("FAIL midrun_async_results got %h/%b/%h exp 000/0/000", err_cnt1, err1, first1); end
        n_vec++; if (ram_rxa1 !== 12'h000) begin n_miss++; $display("FAIL midrun_async_rxa got %h exp 000", ram_rxa1); end
        @(posedge clk); #1;
        rst = 1'b1;
        do_run(1'b0, 8'h05, 1, lat, en_cnt, bad, pc);
        n_vec++; if (lat !== NUM + 4) begin n_miss++; $display("FAIL midrun_restart_latency got %0d exp %0d", lat, NUM + 4); end
        n_vec++; if (err_cnt1 !== 12'h000 || err1 !== 1'b0) begin n_miss++; $display("FAIL midrun_restart_clean got %h/%b exp 000/0", err_cnt1, err1); end
        n_vec++; if (en_cnt !== 3840 || bad !== 0) begin n_miss++; $display("FAIL midrun_restart_reads got %0d/%0d exp 3840/0", en_cnt, bad); end
        fs1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lat3;
        int lat, en_cnt, bad;
        logic [11:0] pc;
        fill(1'b1, 8'h05);
        mem3[12'hEFF] = mem3[12'hEFF] ^ 8'h01;
        do_run(1'b1, 8'h05, 0, lat, en_cnt, bad, pc);
        n_vec++; if (lat !== NUM + 5) begin n_miss++; $display("FAIL lat3_latency got %0d exp %0d", lat, NUM + 5); end
        n_vec++; if (err_cnt3 !== 12'h001) begin n_miss++; $display("FAIL lat3_err_cnt got %h exp 001", err_cnt3); end
        n_vec++; if (first3 !== 12'hEFF) begin n_miss++; $display("FAIL lat3_first got %h exp EFF", first3); end
        n_vec++; if (pc !== 12'h001) begin n_miss++; $display("FAIL lat3_cnt_before_fd got %h exp 001", pc); end
        n_vec++; if (en_cnt !== 3840 || bad !== 0) begin n_miss++; $display("FAIL lat3_reads got %0d/%0d exp 3840/0", en_cnt, bad); end
        fs3 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        fs1 = 1'b0; fs3 = 1'b0;
        bias1 = 8'h00; bias3 = 8'h00;
        fill(1'b0, 8'h05);
        fill(1'b1, 8'h05);
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        test_clean;
        test_corrupt;
        test_bias_mismatch;
        test_hold_restart;
        test_reset_midrun;
        test_lat3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
